// File: rtl/correcao_quadrante_inversa_pkg.sv
// rtl/correcao_quadrante_inversa_pkg.sv - shared quadrant codes, Q16 constants and handshake states
package correcao_quadrante_inversa_pkg;

  localparam logic [2:0] QUAD_0 = 3'b000;
  localparam logic [2:0] QUAD_1 = 3'b001;
  localparam logic [2:0] QUAD_2 = 3'b010;
  localparam logic [2:0] QUAD_3 = 3'b011;
  localparam logic [2:0] QUAD_4 = 3'b100;

  localparam int ONE = 65536;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    MAP     = 3'd2
  } state_t;

endpackage

// File: rtl/correcao_quadrante_inversa_if.sv
// rtl/correcao_quadrante_inversa_if.sv - enable/done handshake and data bus of the inverse quadrant corrector
interface correcao_quadrante_inversa_if #(
  parameter int WIDTH = 32
);
  logic                    enable;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic [2:0]              quadrante;
  logic signed [WIDTH-1:0] cos_out;
  logic signed [WIDTH-1:0] sin_out;
  logic                    busy;
  logic                    quad_err;
  logic                    done;

  modport master (
    output enable, x_in, y_in, quadrante,
    input  cos_out, sin_out, busy, quad_err, done
  );

  modport slave (
    input  enable, x_in, y_in, quadrante,
    output cos_out, sin_out, busy, quad_err, done
  );
endinterface

// File: rtl/correcao_quadrante_inversa_neg_sat.sv
// rtl/correcao_quadrante_inversa_neg_sat.sv - two's complement negator; CORRECAO_INV_SAT_EN saturates -MIN to MAX
module correcao_quadrante_inversa_neg_sat #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] y
);

  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] MAX_VAL = ~MIN_VAL;

`ifdef CORRECAO_INV_SAT_EN
  assign y = (a == MIN_VAL) ? MAX_VAL : -a;
`else
  // Plain wrap: -MIN stays MIN.
  assign y = -a;
`endif

endmodule

// File: rtl/correcao_quadrante_inversa.sv
// rtl/correcao_quadrante_inversa.sv - maps reduced-angle cos/sin back to the original quadrant (macro CORRECAO_INV_SAT_EN)
module correcao_quadrante_inversa
  import correcao_quadrante_inversa_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                          clk,
  input logic                          rst,
  correcao_quadrante_inversa_if.slave  bus
);

  state_t                  state;
  logic signed [WIDTH-1:0] x_cap;
  logic signed [WIDTH-1:0] y_cap;
  logic [2:0]              q_cap;

  logic signed [WIDTH-1:0] c_neg;
  logic signed [WIDTH-1:0] s_neg;
  logic signed [WIDTH-1:0] map_c;
  logic signed [WIDTH-1:0] map_s;
  logic                    map_err;

  correcao_quadrante_inversa_neg_sat #(.WIDTH(WIDTH)) u_neg_c (.a(x_cap), .y(c_neg));
  correcao_quadrante_inversa_neg_sat #(.WIDTH(WIDTH)) u_neg_s (.a(y_cap), .y(s_neg));

  always_comb begin
    map_c   = x_cap;
    map_s   = y_cap;
    map_err = 1'b0;
    case (q_cap)
      QUAD_0: begin map_c = x_cap; map_s = y_cap; end
      QUAD_1: begin map_c = s_neg; map_s = x_cap; end
      QUAD_2,
      QUAD_3: begin map_c = c_neg; map_s = s_neg; end
      QUAD_4: begin map_c = y_cap; map_s = c_neg; end
      default: map_err = 1'b1;
    endcase
  end

  // busy and done are registered views of the state just left, which puts
  // done one edge after MAP and keeps busy aligned with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      x_cap        <= '0;
      y_cap        <= '0;
      q_cap        <= '0;
      bus.cos_out  <= '0;
      bus.sin_out  <= '0;
      bus.quad_err <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.done <= (state == MAP);
      bus.busy <= (state == CAPTURE) || (state == MAP);
      case (state)
        IDLE: begin
          if (bus.enable) begin
            x_cap <= bus.x_in;
            y_cap <= bus.y_in;
            q_cap <= bus.quadrante;
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          bus.cos_out  <= map_c;
          bus.sin_out  <= map_s;
          bus.quad_err <= map_err;
          state        <= MAP;
        end
        MAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_correcao_quadrante_inversa.sv
// tb/tb_correcao_quadrante_inversa.sv - self-checking bench for correcao_quadrante_inversa (honours CORRECAO_INV_SAT_EN)
module tb_correcao_quadrante_inversa;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  correcao_quadrante_inversa_if #(.WIDTH(32)) bus ();

  correcao_quadrante_inversa #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint wneg(input longint v);
    longint r;
    r = -v;
    if (r > 64'sd2147483647) begin
`ifdef CORRECAO_INV_SAT_EN
      r = 64'sd2147483647;
`else
      r = r - 64'sd4294967296;
`endif
    end
    return r;
  endfunction

  // Rotation of the reduced-angle (cos, sin) pair by the quadrant's multiple of 90 degrees.
  task automatic model(input logic [2:0] q, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] ec, output logic [31:0] es, output logic ee);
    longint c, s, rc, rs;
    c  = longint'($signed(x));
    s  = longint'($signed(y));
    ee = 1'b0;
    case (q)
      3'd0:    begin rc = c;       rs = s;       end
      3'd1:    begin rc = wneg(s); rs = c;       end
      3'd2,
      3'd3:    begin rc = wneg(c); rs = wneg(s); end
      3'd4:    begin rc = s;       rs = wneg(c); end
      default: begin rc = c;       rs = s; ee = 1'b1; end
    endcase
    ec = rc[31:0];
    es = rs[31:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [2:0] q, input logic [31:0] x, input logic [31:0] y, input string name);
    logic [31:0] ec, es;
    logic        ee;
    model(q, x, y, ec, es, ee);
    bus.quadrante = q;
    bus.x_in      = x;
    bus.y_in      = y;
    bus.enable    = 1'b1;
    tick();
    bus.enable = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL %s_capture busy=%b done=%b required busy=0 done=0", name, bus.busy, bus.done);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.cos_out !== ec || bus.sin_out !== es || bus.quad_err !== ee) begin
      failures++;
      $display("FAIL %s_map busy=%b done=%b cos=%0d sin=%0d err=%b required busy=1 done=0 cos=%0d sin=%0d err=%b",
               name, bus.busy, bus.done, $signed(bus.cos_out), $signed(bus.sin_out), bus.quad_err,
               $signed(ec), $signed(es), ee);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b1 || bus.cos_out !== ec || bus.sin_out !== es || bus.quad_err !== ee) begin
      failures++;
      $display("FAIL %s_done busy=%b done=%b cos=%0d sin=%0d err=%b required busy=1 done=1 cos=%0d sin=%0d err=%b",
               name, bus.busy, bus.done, $signed(bus.cos_out), $signed(bus.sin_out), bus.quad_err,
               $signed(ec), $signed(es), ee);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cos_out !== ec || bus.sin_out !== es) begin
      failures++;
      $display("FAIL %s_after busy=%b done=%b cos=%0d sin=%0d required busy=0 done=0 cos=%0d sin=%0d",
               name, bus.busy, bus.done, $signed(bus.cos_out), $signed(bus.sin_out), $signed(ec), $signed(es));
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.x_in   = '0;
    bus.y_in   = '0;
    bus.quadrante = '0;
    repeat (2) tick();
    checks++;
    if (bus.cos_out !== '0 || bus.sin_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quad_err !== 1'b0) begin
      failures++;
      $display("FAIL reset cos=%0d sin=%0d busy=%b done=%b err=%b required all 0",
               $signed(bus.cos_out), $signed(bus.sin_out), bus.busy, bus.done, bus.quad_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_quadrants();
    run_one(3'b000, 32'd60000, 32'd20000, "q000");
    run_one(3'b001, 32'd60000, 32'd20000, "q001");
    run_one(3'b100, 32'd60000, 32'd20000, "q100");
    run_one(3'b010, 32'd60000, 32'd20000, "q010");
    run_one(3'b011, 32'd60000, 32'd20000, "q011");
  endtask

  task automatic test_overflow();
    run_one(3'b010, 32'h8000_0000, 32'd0, "neg_min_c");
    run_one(3'b001, 32'd5, 32'h8000_0000, "neg_min_s");
  endtask

  task automatic test_quad_err();
    run_one(3'b110, 32'd1000, -32'sd1000, "q110_err");
    run_one(3'b000, 32'd1000, -32'sd1000, "err_clear");
    run_one(3'b101, 32'd7, 32'd9, "q101_err");
    run_one(3'b111, 32'd11, 32'd13, "q111_err");
  endtask

  task automatic test_random();
    logic [31:0] x, y;
    for (int i = 0; i < 24; i++) begin
      x = $urandom();
      y = $urandom();
      if ((i % 6) == 0) x = 32'h8000_0000;
      if ((i % 6) == 3) y = 32'h8000_0000;
      run_one(3'($urandom_range(0, 7)), x, y, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  q  [0:4];
    logic [31:0] xs [0:4];
    logic [31:0] ys [0:4];
    logic [31:0] ec, es;
    logic        ee;
    for (int k = 0; k < 5; k++) begin
      q[k]  = 3'($urandom_range(0, 7));
      xs[k] = $urandom();
      ys[k] = $urandom();
    end
    bus.quadrante = q[0];
    bus.x_in      = xs[0];
    bus.y_in      = ys[0];
    bus.enable    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.quadrante = q[k+1];
      bus.x_in      = xs[k+1];
      bus.y_in      = ys[k+1];
      tick();
      checks++;
      if (bus.done !== 1'b0) begin
        failures++;
        $display("FAIL b2b_nodone_%0d done=%b required 0", k, bus.done);
      end
      tick();
      if (k == 3) bus.enable = 1'b0;
      model(q[k], xs[k], ys[k], ec, es, ee);
      checks++;
      if (bus.done !== 1'b1 || bus.cos_out !== ec || bus.sin_out !== es || bus.quad_err !== ee) begin
        failures++;
        $display("FAIL b2b_%0d done=%b cos=%0d sin=%0d err=%b required done=1 cos=%0d sin=%0d err=%b",
                 k, bus.done, $signed(bus.cos_out), $signed(bus.sin_out), bus.quad_err,
                 $signed(ec), $signed(es), ee);
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_enable_ignored();
    logic [31:0] ec, es;
    logic        ee;
    int          dones;
    model(3'b001, 32'd12345, -32'sd777, ec, es, ee);
    bus.quadrante = 3'b001;
    bus.x_in      = 32'd12345;
    bus.y_in      = -32'sd777;
    bus.enable    = 1'b1;
    tick();
    bus.x_in = 32'd1;
    bus.y_in = 32'd2;
    dones = 0;
    tick();
    if (bus.done === 1'b1) dones++;
    tick();
    if (bus.done === 1'b1) dones++;
    bus.enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1 || bus.busy !== 1'b0 || bus.cos_out !== ec || bus.sin_out !== es) begin
      failures++;
      $display("FAIL enable_ignored dones=%0d busy=%b cos=%0d sin=%0d required dones=1 busy=0 cos=%0d sin=%0d",
               dones, bus.busy, $signed(bus.cos_out), $signed(bus.sin_out), $signed(ec), $signed(es));
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    run_one(3'b111, 32'd4242, 32'd99, "pre_reset");
    bus.quadrante = 3'b001;
    bus.x_in      = 32'd500;
    bus.y_in      = 32'd600;
    bus.enable    = 1'b1;
    tick();
    bus.enable = 1'b0;
    rst        = 1'b1;
    tick();
    checks++;
    if (bus.cos_out !== '0 || bus.sin_out !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quad_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid cos=%0d sin=%0d busy=%b done=%b err=%b required all 0",
               $signed(bus.cos_out), $signed(bus.sin_out), bus.busy, bus.done, bus.quad_err);
    end
    rst   = 1'b0;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0 || bus.cos_out !== '0) begin
      failures++;
      $display("FAIL reset_mid_after activity=%0d cos=%0d required activity=0 cos=0", dones, $signed(bus.cos_out));
    end
    run_one(3'b100, 32'd300, 32'd400, "post_reset");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_quadrants();
    test_overflow();
    test_quad_err();
    test_random();
    test_back_to_back();
    test_enable_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/correcao_quadrante_inversa.md
Name: correcao_quadrante_inversa

Overview:
Post-processing stage for the CORDIC rotation path, placed after the iteration core. It takes the cos/sin pair computed for the reduced angle in [-π/4, π/4], plus the 3-bit quadrant code produced by the pre-rotation quadrant corrector. It maps that pair back to the cos/sin of the original angle. It uses the same enable/done handshake as the corrector, so the two blocks bracket the core.

Parameters:
WIDTH, 32, width of signed fixed-point data in/out (Q16 format, 65536 = 1.0)

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
enable  input  1  start request; sampled only in IDLE
x_in  input  WIDTH  signed cos(z_reduced) from CORDIC core
y_in  input  WIDTH  signed sin(z_reduced) from CORDIC core
quadrante  input  3  quadrant code from the pre-rotation corrector
cos_out  output  WIDTH  signed cos of the original angle, registered
sin_out  output  WIDTH  signed sin of the original angle, registered
busy  output  1  high in CAPTURE and MAP
quad_err  output  1  registered; high when the captured code was 101..111
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; cos_out, sin_out, quad_err, done, busy all 0; capture registers 0.
- Reset mid-operation: abort to IDLE on the next edge. Discard captured data. No done pulse.
- States (3-bit register):
  - IDLE: if enable=1, latch x_in, y_in and quadrante into capture registers, then go to CAPTURE. Otherwise stay in IDLE.
  - CAPTURE: compute the mapped pair from the capture registers. Register it into cos_out/sin_out. Go to MAP.
  - MAP: assert done for this cycle only. Go to IDLE.
  - Unused encodings: go to IDLE.
- Latency: enable high at edge N leads to new outputs valid after edge N+1, and done=1 during cycle N+2 (after edge N+2).
- Back-to-back: enable held high restarts every 3 cycles.
- enable outside IDLE: ignored, no queuing.
- Outputs hold their last value until the next completion.
- Mapping (c=x_cap, s=y_cap), output pair is (cos_out, sin_out):
  - 000 (-45°..45°): (c, s)
  - 001 (original = z+90°): (-s, c)
  - 010 (original = z+180°): (-c, -s)
  - 011 (original = z+180°, reached via -360°): (-c, -s)
  - 100 (original = z+270°): (s, -c)
  - 101..111: pass-through (c, s) and quad_err=1. quad_err is updated together with the data outputs.
- Arithmetic: negation is two's complement at WIDTH bits. The only overflow case is -(-2^(WIDTH-1)); its handling depends on the optional feature below.
- No gain compensation is applied here; the CORDIC core supplies gain-corrected values.

Optional Feature:
Macro CORRECAO_INV_SAT_EN.
- Defined: negating -2^(WIDTH-1) yields 2^(WIDTH-1)-1 (saturation).
- Undefined: plain wrap, so the result stays -2^(WIDTH-1).
- All other values are identical in both builds.

Decomposition:
- Shared package holds:
  - quadrant code constants QUAD_0..QUAD_4 (000..100); the pre-rotation corrector uses the same constants.
  - Q16 constants (ONE=65536).
  - handshake state encodings IDLE/CAPTURE/MAP.
- One natural sub-module: neg_sat, a parameterised WIDTH negator. The CORRECAO_INV_SAT_EN macro selects its behaviour. It is instantiated twice (c and s paths).

Test Plan:
- quadrante=000, x_in=60000, y_in=20000, enable at edge N -> cos_out=60000, sin_out=20000, done=1 in cycle N+2 only, busy=1 in cycles N+1..N+2.
- quadrante=001, same inputs -> (-20000, 60000). quadrante=100 -> (20000, -60000).
- quadrante=010 and 011, same inputs -> (-60000, -20000) for both. quad_err=0.
- quadrante=010, x_in=-2147483648, y_in=0 -> cos_out=2147483647 with CORRECAO_INV_SAT_EN, -2147483648 without. sin_out=0 in both.
- quadrante=110, x_in=1000, y_in=-1000 -> (1000, -1000), quad_err=1. Next run with 000 -> quad_err=0.
- Control cases:
  - enable pulsed during CAPTURE/MAP -> ignored, single done.
  - rst asserted in CAPTURE -> next cycle state IDLE, outputs 0, no done.
